program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Byte-stream bootloader that writes 14-bit instruction words into the program memory's write port.
- Sits between a UART receiver/transmitter pair (byte valid/ready handshakes) and the program memory.
- Holds the core stalled while it loads, so instruction fetch and programming never overlap.
- Parses framed commands, checks each frame, writes on success and answers every frame with an ACK or NAK byte.

Parameters:
- ADDR_WIDTH, 13, program memory address width; must be ≤16.
- INSTR_WIDTH, 14, instruction width; must be 9..16.
- TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between bytes of one frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  response valid
- tx_ready  in  1  response consumed this cycle
- core_hold  out  1  stall/reset request to core; 1 = core held
- wr_en  out  1  program memory write strobe, one-cycle pulse
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  INSTR_WIDTH  write data
- error_count  out  8  saturating count of NAKs sent

Behaviour:
- Reset: all outputs 0, FSM in IDLE. This includes core_hold, wr_en, rx_ready, tx_valid, tx_data, wr_addr, wr_data and error_count.
- Reset mid-frame discards the partial frame and any pending response. No write occurs.
- A byte transfers when rx_valid & rx_ready are both high in the same cycle.
- A response completes when tx_valid & tx_ready are both high in the same cycle.
- tx_valid and tx_data are held stable until the response completes.
- rx_ready = 1 in IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L and CSUM. It is 0 in WRITE and RESP.
- Commands, each taken in IDLE:
  - 0x42 'B': set core_hold=1 and respond ACK (0x06).
  - 0x45 'E': clear core_hold and respond ACK.
  - 0x4C 'L': go to ADDR_H.
  - Any other byte: respond NAK (0x15) and leave core_hold unchanged.
- Load frame: 'L', addr_hi, addr_lo, data_hi, data_lo, csum. States step ADDR_H → ADDR_L → DATA_H → DATA_L → CSUM, one state per accepted byte.
- Checksum: csum must equal addr_hi ^ addr_lo ^ data_hi ^ data_lo.
- Frame check happens on the cycle csum is accepted. The frame is good only if all of these hold:
  - the checksum matches;
  - bits of {addr_hi,addr_lo} at and above ADDR_WIDTH are 0;
  - bits of {data_hi,data_lo} at and above INSTR_WIDTH are 0;
  - core_hold=1.
- Good frame → WRITE: wr_en=1 for exactly one cycle, with wr_addr/wr_data set to the frame values in that same cycle. Then RESP with ACK.
- Bad frame → RESP with NAK. wr_en stays 0.
- wr_addr/wr_data keep their last values when wr_en=0.
- Write latency: wr_en is asserted the cycle after csum is accepted. tx_valid is asserted the cycle after that.
- RESP: hold tx_valid until tx_ready, then return to IDLE. A response completing in the same cycle a new rx byte arrives is fine: that byte is not accepted until IDLE.
- Timeout: an idle counter runs in ADDR_H..CSUM. It is cleared on every accepted byte. When it reaches TIMEOUT_CYCLES, abort the frame and send NAK via RESP.
- The timeout counter does not run in IDLE, WRITE or RESP.
- error_count increments once per NAK, at the NAK handshake, and saturates at 255.
- core_hold changes only on B/E commands or reset. Load frames never change it.

Decomposition:
- Shared package: command codes (CMD_BEGIN 0x42, CMD_END 0x45, CMD_LOAD 0x4C), response codes (RSP_ACK 0x06, RSP_NAK 0x15), and the FSM state encoding.
- One natural sub-module: loader_timeout. It is the idle-gap counter, with inputs clear/enable and output expired, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Reset, then send 0x42 → core_hold=1, tx ACK 0x06. Send 0x4C,0x00,0x10,0x16,0x83,0x85 → exactly one wr_en pulse with wr_addr=0x0010, wr_data=0x1683, then ACK; error_count=0.
2. With core_hold=1, send 0x4C,0x00,0x10,0x16,0x83,0x84 (bad csum) → no wr_en, NAK 0x15, error_count=1.
3. With core_hold=1, send 0x4C,0x20,0x00,0x00,0x00,0x20 (address bit 13 set) → NAK, no write. Repeat with data 0x4000 (data_hi=0x40, csum=0x40) → NAK, no write.
4. After 0x45, send a valid load frame for address 0x0004, data 0x0009 (csum 0x0D) → core_hold=0, NAK, no write. Send an unknown byte 0x7F → NAK.
5. Send 0x42, then 0x4C,0x00 and stall rx for TIMEOUT_CYCLES (bench uses 16) → NAK at timeout, FSM back in IDLE; a following full valid frame writes normally.
6. Hold tx_ready=0 for 20 cycles after a good frame → tx_valid/tx_data held stable and rx_ready=0 throughout. Assert rst in the middle of a frame → all outputs 0 next cycle and no write.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the byte-stream program loader: command bytes,
//   response bytes, the loader FSM state encoding and the frame checksum.
package program_loader_pkg;

  localparam logic [7:0] CMD_BEGIN = 8'h42;  // 'B': hold the core
  localparam logic [7:0] CMD_END   = 8'h45;  // 'E': release the core
  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L': start a load frame

  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_H = 3'd1,
    ST_ADDR_L = 3'd2,
    ST_DATA_H = 3'd3,
    ST_DATA_L = 3'd4,
    ST_CSUM   = 3'd5,
    ST_WRITE  = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] ah,
                                            input logic [7:0] al,
                                            input logic [7:0] dh,
                                            input logic [7:0] dl);
    return ah ^ al ^ dh ^ dl;
  endfunction

endpackage

// File: rtl/program_loader_timeout.sv
// loader_timeout
//   Idle-gap watchdog for a load frame. Down-counter reloaded to
//   TIMEOUT_CYCLES on clear, decremented on every enabled cycle, and
//   flagging expiry once it reaches zero while still enabled.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   clear   in  reload the counter (byte accepted or not inside a frame)
//   enable  in  count this cycle (inside a frame)
//   expired out TIMEOUT_CYCLES idle cycles have elapsed
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD_VAL;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Byte-stream bootloader. Parses B/E/L commands from a UART receiver,
//   holds the core while programming, writes checked load frames into the
//   program memory write port and answers each command with ACK or NAK.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   rx_data/valid/ready    incoming byte stream (valid/ready handshake)
//   tx_data/valid/ready    response byte stream (valid/ready handshake)
//   core_hold              1 = core stalled
//   wr_en/wr_addr/wr_data  program memory write port (one-cycle strobe)
//   error_count            saturating count of NAKs sent
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a command byte
// ADDR_H    | load frame: waiting for address high byte
// ADDR_L    | load frame: waiting for address low byte
// DATA_H    | load frame: waiting for data high byte
// DATA_L    | load frame: waiting for data low byte
// CSUM      | load frame: waiting for checksum, frame checked on accept
// WRITE     | write strobe active this cycle
// RESP      | response byte offered until tx_ready
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned INSTR_WIDTH    = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   core_hold,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic [7:0]             error_count
);

  state_t                 state_q;
  logic                   hold_q;
  logic                   rx_ready_q;
  logic                   tx_valid_q;
  logic [7:0]             tx_data_q;
  logic                   wr_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [INSTR_WIDTH-1:0] wr_data_q;
  logic [7:0]             err_q;
  logic [7:0]             addr_h_q;
  logic [7:0]             addr_l_q;
  logic [7:0]             data_h_q;
  logic [7:0]             data_l_q;

  logic        rx_fire;
  logic        in_frame;
  logic        tmo_expired;
  logic [15:0] addr_full;
  logic [15:0] data_full;
  logic        csum_ok;
  logic        addr_ok;
  logic        data_ok;
  logic        frame_good;

  // rx_ready_q is kept in step with the state, so an accepted byte always
  // belongs to one of the byte-collecting states.
  assign rx_fire  = rx_valid && rx_ready_q;
  assign in_frame = (state_q == ST_ADDR_H) || (state_q == ST_ADDR_L) ||
                    (state_q == ST_DATA_H) || (state_q == ST_DATA_L) ||
                    (state_q == ST_CSUM);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_fire || !in_frame),
    .enable (in_frame),
    .expired(tmo_expired)
  );

  // Frame check runs while the checksum byte is on rx_data.
  assign addr_full  = {addr_h_q, addr_l_q};
  assign data_full  = {data_h_q, data_l_q};
  assign csum_ok    = (rx_data == frame_csum(addr_h_q, addr_l_q, data_h_q, data_l_q));
  assign addr_ok    = ((addr_full >> ADDR_WIDTH) == 16'h0000);
  assign data_ok    = ((data_full >> INSTR_WIDTH) == 16'h0000);
  assign frame_good = csum_ok && addr_ok && data_ok && hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 8'h00;
      addr_h_q   <= 8'h00;
      addr_l_q   <= 8'h00;
      data_h_q   <= 8'h00;
      data_l_q   <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            if (rx_data == CMD_LOAD) begin
              state_q <= ST_ADDR_H;
            end else begin
              if (rx_data == CMD_BEGIN) hold_q <= 1'b1;
              if (rx_data == CMD_END)   hold_q <= 1'b0;
              state_q    <= ST_RESP;
              rx_ready_q <= 1'b0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ((rx_data == CMD_BEGIN) || (rx_data == CMD_END)) ? RSP_ACK : RSP_NAK;
            end
          end
        end
        ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L: begin
          // An accepted byte wins over a coincident expiry: it restarts the gap.
          if (rx_fire) begin
            case (state_q)
              ST_ADDR_H: begin addr_h_q <= rx_data; state_q <= ST_ADDR_L; end
              ST_ADDR_L: begin addr_l_q <= rx_data; state_q <= ST_DATA_H; end
              ST_DATA_H: begin data_h_q <= rx_data; state_q <= ST_DATA_L; end
              default:   begin data_l_q <= rx_data; state_q <= ST_CSUM;   end
            endcase
          end else if (tmo_expired) begin
            state_q    <= ST_RESP;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= RSP_NAK;
          end
        end
        ST_CSUM: begin
          if (rx_fire) begin
            rx_ready_q <= 1'b0;
            if (frame_good) begin
              state_q   <= ST_WRITE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_full[ADDR_WIDTH-1:0];
              wr_data_q <= data_full[INSTR_WIDTH-1:0];
            end else begin
              state_q    <= ST_RESP;
              tx_valid_q <= 1'b1;
              tx_data_q  <= RSP_NAK;
            end
          end else if (tmo_expired) begin
            state_q    <= ST_RESP;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= RSP_NAK;
          end
        end
        ST_WRITE: begin
          state_q    <= ST_RESP;
          tx_valid_q <= 1'b1;
          tx_data_q  <= RSP_ACK;
        end
        ST_RESP: begin
          if (tx_ready) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            if ((tx_data_q == RSP_NAK) && (err_q != 8'hFF)) begin
              err_q <= err_q + 8'd1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          rx_ready_q <= 1'b0;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign core_hold   = hold_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign error_count = err_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int TMO = 16;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        core_hold;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [13:0] wr_data;
  logic [7:0]  error_count;

  program_loader #(
    .ADDR_WIDTH(13),
    .INSTR_WIDTH(14),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .core_hold(core_hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wexp_t;

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  b [6];
    logic [7:0]  rsp;
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    bit          hold;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_exp  = 0;
  wexp_t       wq [$];
  logic [7:0]  txq [$];
  wexp_t       w_mon;
  logic [7:0]  t_mon;
  vec_t        vecs [10];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string nm, input int n,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [7:0] b4, input logic [7:0] b5,
                               input logic [7:0] rsp, input bit wr,
                               input logic [15:0] a, input logic [15:0] d,
                               input bit hold);
    vec_t v;
    v.name = nm; v.n = n;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
    v.rsp = rsp; v.wr = wr; v.a = a; v.d = d; v.hold = hold;
    return v;
  endfunction

  // Scoreboard: writes and response bytes are popped as the DUT produces them.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        chk("write_expected", longint'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          w_mon = wq.pop_front();
          chk("wr_addr", wr_addr, w_mon.a);
          chk("wr_data", wr_data, w_mon.d);
        end
      end
      if (tx_valid && tx_ready) begin
        chk("resp_expected", longint'(txq.size() > 0), 1);
        if (txq.size() > 0) begin
          t_mon = txq.pop_front();
          chk("tx_data", tx_data, t_mon);
        end
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!rx_ready && k < 200);
    if (!rx_ready) chk("rx_accept_timeout", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while ((txq.size() != 0 || wq.size() != 0) && k < 300);
    chk({nm, "_drain"}, txq.size() + wq.size(), 0);
    txq.delete();
    wq.delete();
  endtask

  task automatic push_rsp(input logic [7:0] r);
    txq.push_back(r);
    if (r == NAK && err_exp < 255) err_exp++;
  endtask

  initial begin
    int k;
    vec_t v;

    vecs[0] = mkv("begin",      1, 8'h42, 0, 0, 0, 0, 0,             ACK, 1, 0, 0, 1);
    vecs[1] = mkv("load_ok",    6, 8'h4C, 8'h00, 8'h10, 8'h16, 8'h83, 8'h85, ACK, 1, 16'h0010, 16'h1683, 1);
    vecs[2] = mkv("bad_csum",   6, 8'h4C, 8'h00, 8'h10, 8'h16, 8'h83, 8'h84, NAK, 0, 0, 0, 1);
    vecs[3] = mkv("addr_bit13", 6, 8'h4C, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, NAK, 0, 0, 0, 1);
    vecs[4] = mkv("data_bit14", 6, 8'h4C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, NAK, 0, 0, 0, 1);
    vecs[5] = mkv("load_max",   6, 8'h4C, 8'h1F, 8'hFF, 8'h3F, 8'hFF, 8'h20, ACK, 1, 16'h1FFF, 16'h3FFF, 1);
    vecs[6] = mkv("end",        1, 8'h45, 0, 0, 0, 0, 0,             ACK, 0, 0, 0, 0);
    vecs[7] = mkv("load_nohold",6, 8'h4C, 8'h00, 8'h04, 8'h00, 8'h09, 8'h0D, NAK, 0, 0, 0, 0);
    vecs[8] = mkv("unknown",    1, 8'h7F, 0, 0, 0, 0, 0,             NAK, 0, 0, 0, 0);
    vecs[9] = mkv("begin2",     1, 8'h42, 0, 0, 0, 0, 0,             ACK, 0, 0, 0, 1);
    vecs[9].wr = 0;
    vecs[0].wr = 0;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready",    rx_ready, 0);
    chk("rst_tx_valid",    tx_valid, 0);
    chk("rst_tx_data",     tx_data, 0);
    chk("rst_core_hold",   core_hold, 0);
    chk("rst_wr_en",       wr_en, 0);
    chk("rst_wr_addr",     wr_addr, 0);
    chk("rst_wr_data",     wr_data, 0);
    chk("rst_error_count", error_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_rx_ready", rx_ready, 1);

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      push_rsp(v.rsp);
      if (v.wr) wq.push_back('{a: v.a, d: v.d});
      for (int j = 0; j < v.n; j++) send_byte(v.b[j]);
      wait_done(v.name);
      chk({v.name, "_error_count"}, error_count, err_exp);
      chk({v.name, "_core_hold"}, core_hold, v.hold);
    end

    // Idle gap inside a frame aborts it with NAK after TMO cycles.
    push_rsp(NAK);
    send_byte(8'h4C);
    send_byte(8'h00);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!tx_valid && k < 4 * TMO);
    chk("timeout_nak_seen", tx_valid, 1);
    chk("timeout_not_early", longint'(k >= TMO), 1);
    chk("timeout_not_late", longint'(k <= TMO + 2), 1);
    wait_done("timeout");
    chk("timeout_error_count", error_count, err_exp);
    chk("timeout_idle_rx_ready", rx_ready, 1);

    push_rsp(ACK);
    wq.push_back('{a: 16'h0ABC, d: 16'h1234});
    send_byte(8'h4C); send_byte(8'h0A); send_byte(8'hBC);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h90);
    wait_done("after_timeout");

    // Response stalled by tx_ready: byte must be held, rx blocked; a byte
    // offered during the stall is taken only after returning to IDLE.
    tx_ready = 1'b0;
    push_rsp(ACK);
    wq.push_back('{a: 16'h0005, d: 16'h0007});
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h07); send_byte(8'h02);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!tx_valid && k < 20);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin
        rx_data  = 8'h45;
        rx_valid = 1'b1;
      end
      chk("stall_tx_valid", tx_valid, 1);
      chk("stall_tx_data", tx_data, ACK);
      chk("stall_rx_ready", rx_ready, 0);
    end
    push_rsp(ACK);
    tx_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rx_ready && k < 50);
    chk("stall_then_rx_ready", rx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    wait_done("stall");
    chk("stall_core_hold", core_hold, 0);
    chk("stall_error_count", error_count, err_exp);

    // Reset in the middle of a frame.
    push_rsp(ACK);
    send_byte(8'h42);
    wait_done("begin3");
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rx_ready",    rx_ready, 0);
    chk("midrst_tx_valid",    tx_valid, 0);
    chk("midrst_tx_data",     tx_data, 0);
    chk("midrst_core_hold",   core_hold, 0);
    chk("midrst_wr_en",       wr_en, 0);
    chk("midrst_wr_addr",     wr_addr, 0);
    chk("midrst_wr_data",     wr_data, 0);
    chk("midrst_error_count", error_count, 0);
    rst = 1'b0;
    err_exp = 0;
    push_rsp(NAK);
    send_byte(8'h7F);
    wait_done("post_reset");
    chk("post_reset_error_count", error_count, err_exp);
    chk("post_reset_core_hold", core_hold, 0);

    // error_count saturates at 255.
    for (int i = 0; i < 260; i++) begin
      push_rsp(NAK);
      send_byte(8'h7F);
      wait_done("sat");
    end
    chk("sat_error_count", error_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
